// File: rtl/sample_feeder.sv
// Sample memory that the host loads and the neuron controller streams through, one sample per next pulse.
// x1/x2/t1 and EOF are registered, so they are valid the cycle after an init or next pulse.
module sample_feeder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_x1,
    input  logic [DATA_W-1:0]   wr_x2,
    input  logic                wr_t1,
    input  logic                clr,
    input  logic                init_file_handler,
    input  logic                next,
    output logic [DATA_W-1:0]   x1,
    output logic [DATA_W-1:0]   x2,
    output logic                t1,
    output logic                EOF,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                busy,
    output logic                wr_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned SMP_W = 2 * DATA_W + 1;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    logic [SMP_W-1:0]  mem [DEPTH];

    logic              state_q, state_d;
    logic [CNT_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SMP_W-1:0]  smp_q, smp_d;
    logic              eof_q, eof_d;
    logic              full_q, full_d;
    logic              wr_err_q, wr_err_d;

    logic              wr_ok_c;
    logic [CNT_W-1:0]  ptr_inc_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [SMP_W-1:0]  rd_data_c;

    // Reads sample 0 on a rewind, otherwise the sample after the current one.
    assign ptr_inc_c = ptr_q + CNT_W'(1);
    assign rd_addr_c = (state_q == ST_STREAM && !init_file_handler) ?
                       ptr_inc_c[ADDR_W-1:0] : ADDR_W'(0);
    assign rd_data_c = mem[rd_addr_c];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        smp_d    = smp_q;
        eof_d    = eof_q;
        wr_err_d = 1'b0;
        wr_ok_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (init_file_handler && count_q != '0) begin
                    state_d = ST_STREAM;
                    ptr_d   = '0;
                    smp_d   = rd_data_c;
                    eof_d   = 1'b0;
                end
                // clr beats a simultaneous write and suppresses its error.
                if (clr) begin
                    count_d = '0;
                end else if (wr_en) begin
                    if (full_q) begin
                        wr_err_d = 1'b1;
                    end else begin
                        wr_ok_c = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                wr_err_d = wr_en;
                if (init_file_handler) begin
                    ptr_d = '0;
                    smp_d = rd_data_c;
                    eof_d = 1'b0;
                end else if (next) begin
                    // Compare at CNT_W bits so a completely full memory does not wrap.
                    if (ptr_inc_c < count_q) begin
                        ptr_d = ptr_inc_c;
                        smp_d = rd_data_c;
                    end else begin
                        ptr_d   = count_q;
                        eof_d   = 1'b1;
                        smp_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            count_q  <= '0;
            smp_q    <= '0;
            eof_q    <= 1'b1;
            full_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            smp_q    <= smp_d;
            eof_q    <= eof_d;
            full_q   <= full_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[count_q[ADDR_W-1:0]] <= {wr_t1, wr_x2, wr_x1};
        end
    end

    assign x1     = smp_q[DATA_W-1:0];
    assign x2     = smp_q[2*DATA_W-1:DATA_W];
    assign t1     = smp_q[SMP_W-1];
    assign EOF    = eof_q;
    assign count  = count_q;
    assign full   = full_q;
    assign busy   = (state_q == ST_STREAM);
    assign wr_err = wr_err_q;

endmodule
